writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Registered, parametrised writeback stage for the ARM calculator pipeline.
- Accepts one retiring instruction at a time from the memory stage.
- For loads, waits for memory read data and extracts/extends the byte, halfword or word.
- Selects among link value, load data and ALU result, then presents one registered register-file commit per instruction; keeps a retired-instruction counter.

Parameters:
DATA_W, 32, datapath width; multiple of 8, >= 32
REG_ADDR_W, 4, register index width
LINK_REG, 14, destination index for link writes
PC_REG, 15, register index treated as the PC
LINK_OFFSET, 4, added to pc for link value

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  instruction offered
in_ready  out  1  unit can accept (combinational: state==IDLE)
flush  in  1  kill pending/offered instruction
alu_result  in  DATA_W  ALU result
pc  in  DATA_W  instruction address
rd_addr  in  REG_ADDR_W  destination register
reg_write  in  1  instruction writes a register
mem_to_reg  in  1  instruction is a load
link  in  1  branch-with-link
load_size  in  2  00 word, 01 half, 10 byte, 11 = word
load_signed  in  1  sign-extend sub-word load
addr_lo  in  $clog2(DATA_W/8)  low load address bits
mem_rdata  in  DATA_W  memory read data
mem_rvalid  in  1  mem_rdata valid
wb_valid  out  1  one-cycle commit pulse
wb_we  out  1  register-file write enable
wb_addr  out  REG_ADDR_W  write index
wb_data  out  DATA_W  write data
pc_write  out  1  wb_we and wb_addr==PC_REG
retired  out  DATA_W  count of commits

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE.
  - wb_valid, wb_we, pc_write, wb_addr, wb_data and retired all 0.
  - Latched instruction fields cleared.
  - Reset during WAIT abandons the load with no commit.
- FSM states: IDLE, WAIT.
- Accept = in_valid & in_ready & ~flush. A flush on the accept cycle drops the offered instruction.
- IDLE, accept, link=1 or mem_to_reg=0: commit registered at the next edge; wb_valid is high in cycle N+1; stay IDLE. Back-to-back accepts give a commit every cycle.
- IDLE, accept, link=0 and mem_to_reg=1: latch rd_addr, reg_write, load_size, load_signed, addr_lo; go to WAIT. in_ready=0 while in WAIT.
- WAIT:
  - mem_rvalid is sampled only in WAIT; an rvalid on the accept cycle is ignored.
  - mem_rvalid=1 and flush=0: extract data, commit at the next edge, return to IDLE.
  - flush=1: return to IDLE, no commit, regardless of mem_rvalid (flush wins).
  - Otherwise remain in WAIT, no timeout.
- A commit already registered (wb_valid high) is never cancelled by flush.
- Data selection priority:
  - link: wb_data = pc + LINK_OFFSET, modulo 2^DATA_W; wb_addr = LINK_REG.
  - Else load: extracted data, wb_addr = rd_addr.
  - Else alu_result, wb_addr = rd_addr.
- Extraction:
  - Byte lane k = addr_lo: bits [8k+7:8k].
  - Half lane = addr_lo[msb:1], addr_lo[0] ignored: bits [16h+15:16h].
  - Sub-word values are zero-extended, or sign-extended when load_signed=1.
  - Word: mem_rdata unchanged; load_signed ignored.
- wb_we = reg_write | link.
- pc_write = wb_valid & wb_we & (wb_addr==PC_REG).
- wb_we, pc_write and wb_valid are 0 in every non-commit cycle. wb_addr and wb_data hold their last value between commits.
- retired increments by 1 on every commit cycle, including wb_we=0 commits; wraps all-ones -> 0.

Test Plan:
1. Reset, then ALU op: alu_result=0x0000_1234, rd=3, reg_write=1, accepted cycle N -> cycle N+1: wb_valid=1, wb_we=1, wb_addr=3, wb_data=0x0000_1234, retired=1; all outputs 0 during reset.
2. Signed byte load: addr_lo=2, mem_rvalid 3 cycles after accept with mem_rdata=0x1180_FF22 -> in_ready=0 while waiting; commit the cycle after rvalid with wb_data=0x0000_0080 (unsigned) / 0xFFFF_FF80 (signed).
3. Half load: addr_lo=3, load_signed=1, mem_rdata=0x8001_7FFF -> wb_data=0xFFFF_8001. Word load with the same data -> 0x8001_7FFF.
4. BL: link=1, pc=0xFFFF_FFFE, rd=15 -> wb_addr=14, wb_data=0x0000_0002 (wrap), pc_write=0. ALU write with rd=15 -> pc_write=1.
5. Flush in WAIT on the same cycle as mem_rvalid -> no wb_valid, back to IDLE, retired unchanged. Flush on an accept cycle -> instruction dropped.
6. Three back-to-back ALU ops, the second with reg_write=0 -> wb_valid high three consecutive cycles, wb_we=1,0,1; retired preloaded to 0xFFFF_FFFF wraps to 0x0000_0002.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: accepts one retiring instruction, waits for load data when needed,
// and presents a single registered register-file commit per instruction.
module writeback_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned LINK_REG    = 14,
  parameter int unsigned PC_REG      = 15,
  parameter int unsigned LINK_OFFSET = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          flush,
  input  logic [DATA_W-1:0]             alu_result,
  input  logic [DATA_W-1:0]             pc,
  input  logic [REG_ADDR_W-1:0]         rd_addr,
  input  logic                          reg_write,
  input  logic                          mem_to_reg,
  input  logic                          link,
  input  logic [1:0]                    load_size,
  input  logic                          load_signed,
  input  logic [$clog2(DATA_W/8)-1:0]   addr_lo,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_rvalid,
  output logic                          wb_valid,
  output logic                          wb_we,
  output logic [REG_ADDR_W-1:0]         wb_addr,
  output logic [DATA_W-1:0]             wb_data,
  output logic                          pc_write,
  output logic [DATA_W-1:0]             retired
);

  localparam int unsigned LO_W = $clog2(DATA_W/8);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  logic [0:0]            state_q, state_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [LO_W-1:0]       lo_q, lo_d;

  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_we_q, wb_we_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  pc_write_q, pc_write_d;
  logic [DATA_W-1:0]     retired_q, retired_d;

  logic                  accept;
  logic                  commit;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [DATA_W-1:0]     load_data;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready & ~flush;

  // Lane extraction uses only the latched load attributes
  always_comb begin
    byte_v = 8'(mem_rdata >> {lo_q, 3'b000});
    half_v = 16'(mem_rdata >> {lo_q[LO_W-1:1], 4'b0000});
    case (size_q)
      SIZE_BYTE: load_data = {{(DATA_W-8){sgn_q & byte_v[7]}}, byte_v};
      SIZE_HALF: load_data = {{(DATA_W-16){sgn_q & half_v[15]}}, half_v};
      default:   load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    we_d       = we_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    lo_d       = lo_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    pc_write_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    retired_d  = retired_q;
    commit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (link) begin
            commit    = 1'b1;
            wb_we_d   = 1'b1;
            wb_addr_d = REG_ADDR_W'(LINK_REG);
            wb_data_d = pc + DATA_W'(LINK_OFFSET);
          end else if (!mem_to_reg) begin
            commit    = 1'b1;
            wb_we_d   = reg_write;
            wb_addr_d = rd_addr;
            wb_data_d = alu_result;
          end else begin
            rd_d    = rd_addr;
            we_d    = reg_write;
            size_d  = load_size;
            sgn_d   = load_signed;
            lo_d    = addr_lo;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mem_rvalid) begin
          commit    = 1'b1;
          wb_we_d   = we_q;
          wb_addr_d = rd_q;
          wb_data_d = load_data;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      wb_valid_d = 1'b1;
      pc_write_d = wb_we_d & (wb_addr_d == REG_ADDR_W'(PC_REG));
      retired_d  = retired_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      lo_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      pc_write_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      lo_q       <= lo_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      pc_write_q <= pc_write_d;
      retired_q  <= retired_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign pc_write = pc_write_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: hand-computed expectations for ALU, load,
// link, flush, reset-in-wait and retired-counter wrap.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [3:0]  rd_addr;
  logic        reg_write;
  logic        mem_to_reg;
  logic        link;
  logic [1:0]  load_size;
  logic        load_signed;
  logic [1:0]  addr_lo;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        wb_valid;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pc_write;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret;

  writeback_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .alu_result(alu_result), .pc(pc), .rd_addr(rd_addr), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .link(link), .load_size(load_size), .load_signed(load_signed),
    .addr_lo(addr_lo), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_write(pc_write), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; alu_result = 0; pc = 0; rd_addr = 0; reg_write = 0;
    mem_to_reg = 0; link = 0; load_size = 0; load_signed = 0; addr_lo = 0;
    mem_rdata = 0; mem_rvalid = 0;
  endtask

  task automatic alu_op(input logic [3:0] rd, input logic we, input logic [31:0] res);
    idle_inputs();
    in_valid = 1; rd_addr = rd; reg_write = we; alu_result = res;
  endtask

  // Accept a load (rvalid on the accept cycle must be ignored), wait, then return data
  task automatic load_op(input string tag, input logic [3:0] rd, input logic [1:0] size,
                         input logic sgn, input logic [1:0] lo, input logic [31:0] data,
                         input logic [31:0] exp);
    idle_inputs();
    in_valid = 1; mem_to_reg = 1; reg_write = 1; rd_addr = rd; load_size = size;
    load_signed = sgn; addr_lo = lo; mem_rdata = data; mem_rvalid = 1;
    tick();
    idle_inputs();
    mem_rdata = data;
    for (int i = 0; i < 2; i++) begin
      check({tag, " wait ready"}, 32'(in_ready), 32'd0);
      check({tag, " wait valid"}, 32'(wb_valid), 32'd0);
      tick();
    end
    mem_rvalid = 1;
    tick();
    exp_ret = exp_ret + 1;
    mem_rvalid = 0;
    check({tag, " valid"}, 32'(wb_valid), 32'd1);
    check({tag, " we"}, 32'(wb_we), 32'd1);
    check({tag, " addr"}, 32'(wb_addr), 32'(rd));
    check({tag, " data"}, wb_data, exp);
    check({tag, " retired"}, retired, exp_ret);
    check({tag, " ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    exp_ret = 0;
    tick(); tick();
    check("rst valid", 32'(wb_valid), 0);
    check("rst we", 32'(wb_we), 0);
    check("rst pcw", 32'(pc_write), 0);
    check("rst addr", 32'(wb_addr), 0);
    check("rst data", wb_data, 0);
    check("rst retired", retired, 0);
    check("rst ready", 32'(in_ready), 1);
    rst_n = 1;

    // ALU commit, then hold between commits
    alu_op(4'd3, 1'b1, 32'h0000_1234);
    tick();
    exp_ret = 1;
    check("alu valid", 32'(wb_valid), 1);
    check("alu we", 32'(wb_we), 1);
    check("alu addr", 32'(wb_addr), 3);
    check("alu data", wb_data, 32'h0000_1234);
    check("alu retired", retired, 1);
    idle_inputs();
    tick();
    check("hold valid", 32'(wb_valid), 0);
    check("hold we", 32'(wb_we), 0);
    check("hold data", wb_data, 32'h0000_1234);

    load_op("ldrb u", 4'd5, 2'b10, 1'b0, 2'd2, 32'h1180_FF22, 32'h0000_0080);
    load_op("ldrb s", 4'd6, 2'b10, 1'b1, 2'd2, 32'h1180_FF22, 32'hFFFF_FF80);
    load_op("ldrb s1", 4'd7, 2'b10, 1'b1, 2'd1, 32'h1180_FF22, 32'hFFFF_FFFF);
    load_op("ldrh s", 4'd8, 2'b01, 1'b1, 2'd3, 32'h8001_7FFF, 32'hFFFF_8001);
    load_op("ldrh u", 4'd9, 2'b01, 1'b0, 2'd1, 32'h8001_7FFF, 32'h0000_7FFF);
    load_op("ldr", 4'd10, 2'b00, 1'b1, 2'd0, 32'h8001_7FFF, 32'h8001_7FFF);
    load_op("ldr 11", 4'd11, 2'b11, 1'b1, 2'd2, 32'h8001_7FFF, 32'h8001_7FFF);

    // BL with wrap; link overrides mem_to_reg and rd
    idle_inputs();
    in_valid = 1; link = 1; pc = 32'hFFFF_FFFE; rd_addr = 4'd15; mem_to_reg = 1;
    alu_result = 32'hDEAD_BEEF;
    tick();
    exp_ret = exp_ret + 1;
    check("bl valid", 32'(wb_valid), 1);
    check("bl we", 32'(wb_we), 1);
    check("bl addr", 32'(wb_addr), 14);
    check("bl data", wb_data, 32'h0000_0002);
    check("bl pcw", 32'(pc_write), 0);
    check("bl ready", 32'(in_ready), 1);
    alu_op(4'd15, 1'b1, 32'h0000_0100);
    tick();
    exp_ret = exp_ret + 1;
    check("pc pcw", 32'(pc_write), 1);
    check("pc addr", 32'(wb_addr), 15);
    idle_inputs();
    tick();
    check("pc pcw clr", 32'(pc_write), 0);

    // Flush in WAIT together with rvalid
    idle_inputs();
    in_valid = 1; mem_to_reg = 1; reg_write = 1; rd_addr = 4'd2;
    tick();
    idle_inputs();
    flush = 1; mem_rvalid = 1; mem_rdata = 32'h1111_1111;
    tick();
    check("fl wait valid", 32'(wb_valid), 0);
    check("fl wait ready", 32'(in_ready), 1);
    flush = 0;
    tick();
    check("fl late rvalid", 32'(wb_valid), 0);
    check("fl retired", retired, exp_ret);

    // Flush on accept drops both ALU and load offers
    alu_op(4'd4, 1'b1, 32'h5555_5555);
    flush = 1;
    tick();
    check("fl acc valid", 32'(wb_valid), 0);
    idle_inputs();
    in_valid = 1; mem_to_reg = 1; flush = 1;
    tick();
    check("fl acc ld ready", 32'(in_ready), 1);
    check("fl acc retired", retired, exp_ret);

    // Reset in WAIT abandons the load
    idle_inputs();
    in_valid = 1; mem_to_reg = 1; reg_write = 1; rd_addr = 4'd1;
    tick();
    idle_inputs();
    rst_n = 0; mem_rvalid = 1;
    tick();
    exp_ret = 0;
    check("rstw valid", 32'(wb_valid), 0);
    check("rstw retired", retired, 0);
    check("rstw ready", 32'(in_ready), 1);
    rst_n = 1;
    idle_inputs();
    tick();
    check("rstw no commit", 32'(wb_valid), 0);

    // Back-to-back ALU ops with counter wrap
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    alu_op(4'd1, 1'b1, 32'hA);
    tick();
    check("b2b0 valid", 32'(wb_valid), 1);
    check("b2b0 we", 32'(wb_we), 1);
    check("b2b0 retired", retired, 32'h0000_0000);
    alu_op(4'd2, 1'b0, 32'hB);
    tick();
    check("b2b1 valid", 32'(wb_valid), 1);
    check("b2b1 we", 32'(wb_we), 0);
    check("b2b1 data", wb_data, 32'hB);
    check("b2b1 retired", retired, 32'h0000_0001);
    alu_op(4'd3, 1'b1, 32'hC);
    tick();
    check("b2b2 valid", 32'(wb_valid), 1);
    check("b2b2 we", 32'(wb_we), 1);
    check("b2b2 retired", retired, 32'h0000_0002);
    idle_inputs();
    tick();
    check("b2b end valid", 32'(wb_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
